// File: rtl/mem_wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_pkg
//
// These declarations are shared by the memory stage, the MEM/WB stage and the
// hazard/forwarding unit:
//   - default data and register-index widths
//   - the write-back slot record {valid, data, rd, reg_write, out}
//   - small helpers that decide what a slot does when it commits
// -----------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_REG_ADDR_WIDTH = 3;
    localparam int DEF_REG_COUNT      = 2 ** DEF_REG_ADDR_WIDTH;

    // One write-back slot at the default widths.
    typedef struct packed {
        logic                          valid;
        logic [DEF_DATA_WIDTH-1:0]     data;
        logic [DEF_REG_ADDR_WIDTH-1:0] rd;
        logic                          reg_write;
        logic                          out;
    } wb_slot_t;

    localparam wb_slot_t WB_BUBBLE = '0;

    // A bubble never writes the register file, whatever its reg_write bit says.
    function automatic logic wb_slot_writes(input wb_slot_t slot);
        return slot.valid & slot.reg_write;
    endfunction

    // A bubble never pulses the OUT port, whatever its out bit says.
    function automatic logic wb_slot_outputs(input wb_slot_t slot);
        return slot.valid & slot.out;
    endfunction

endpackage : mem_wb_stage_pkg

// File: rtl/mem_wb_stage_register_file.sv
// -----------------------------------------------------------------------------
// mem_wb_stage_register_file
//
// This is a 2**ADDR_WIDTH x DATA_WIDTH register file.
//   - one synchronous write port
//   - two asynchronous read ports
//   - asynchronous reset clears every entry to zero
//   - there is no hard-wired zero register, so every entry can be written
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high; clears all entries
//   we       write enable
//   waddr    write index
//   wdata    write data
//   raddr_a  read port A index
//   raddr_b  read port B index
//   rdata_a  read port A data, taken straight from storage with no bypass
//   rdata_b  read port B data, taken straight from storage with no bypass
// -----------------------------------------------------------------------------
module mem_wb_stage_register_file
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]      wsel;

    // Each entry is its own register. The entries must reset asynchronously,
    // which rules out a block-RAM mapping.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wsel[gi] = we && (waddr == ADDR_WIDTH'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (wsel[gi]) begin
                    mem_reg[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata_a = mem_reg[raddr_a];
    assign rdata_b = mem_reg[raddr_b];

endmodule : mem_wb_stage_register_file

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// This is the MEM/WB pipeline register and the write-back logic behind it.
// It holds one slot {valid, data, rd, reg_write, out} and commits that slot at
// the edge that ends its WB cycle:
//   - valid & reg_write : the register file is written
//   - valid & out       : out_port is updated and out_valid pulses for 1 cycle
// Decode reads the register file through two combinational ports. Those ports
// use a write-first bypass from the slot. The hazard unit reads a forwarding
// tap that is taken from the slot.
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   stall                 hold: commit the current slot, then empty it
//   flush                 load a bubble into the slot (wins over stall)
//   data_in, rd_in,
//   reg_write_in, out_in,
//   valid_in              incoming slot contents from the memory stage
//   rs_addr / rs_data     read port A
//   rt_addr / rt_data     read port B
//   fwd_valid, fwd_rd,
//   fwd_data              forwarding tap: the slot will write rd at the next edge
//   out_port, out_valid   registered OUT port and its one-cycle update strobe
// -----------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    input  logic                      reg_write_in,
    input  logic                      out_in,
    input  logic                      valid_in,
    input  logic [REG_ADDR_WIDTH-1:0] rs_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0]     rs_data,
    output logic [DATA_WIDTH-1:0]     rt_data,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [DATA_WIDTH-1:0]     out_port,
    output logic                      out_valid
);

    // The slot is the package record rebuilt at this instance's widths.
    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     data;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      out;
    } slot_t;

    slot_t                 slot_reg;
    slot_t                 slot_next;
    logic                  commit_write;
    logic                  commit_out;
    logic [DATA_WIDTH-1:0] out_port_reg;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] rf_rs_data;
    logic [DATA_WIDTH-1:0] rf_rt_data;

    // Only a real instruction may commit. A bubble's control bits are ignored.
    assign commit_write = slot_reg.valid & slot_reg.reg_write;
    assign commit_out   = slot_reg.valid & slot_reg.out;

    // Slot update order is flush, then stall, then capture. On flush and on
    // stall only the valid bit is cleared. The other fields keep their old
    // values, and nothing can use them once valid is low. Clearing valid on a
    // stall stops the instruction that just committed from committing again.
    always_comb begin
        slot_next = slot_reg;
        if (flush || stall) begin
            slot_next.valid = 1'b0;
        end else begin
            slot_next.valid     = valid_in;
            slot_next.data      = data_in;
            slot_next.rd        = rd_in;
            slot_next.reg_write = reg_write_in;
            slot_next.out       = out_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_next;
        end
    end

    // The OUT port. The strobe is high for exactly the cycle after an OUT
    // commit. out_port keeps its value until the next OUT commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= commit_out;
            if (commit_out) begin
                out_port_reg <= slot_reg.data;
            end
        end
    end

    assign out_port  = out_port_reg;
    assign out_valid = out_valid_reg;

    mem_wb_stage_register_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_register_file (
        .clk     (clk),
        .reset   (reset),
        .we      (commit_write),
        .waddr   (slot_reg.rd),
        .wdata   (slot_reg.data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rf_rs_data),
        .rdata_b (rf_rt_data)
    );

    // Write-first bypass. Decode sees the slot's value during the cycle
    // before that value lands in the register file, so no read is stale.
    always_comb begin
        rs_data = rf_rs_data;
        rt_data = rf_rt_data;
        if (commit_write && (slot_reg.rd == rs_addr)) begin
            rs_data = slot_reg.data;
        end
        if (commit_write && (slot_reg.rd == rt_addr)) begin
            rt_data = slot_reg.data;
        end
    end

    assign fwd_valid = commit_write;
    assign fwd_rd    = slot_reg.rd;
    assign fwd_data  = slot_reg.data;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed bench for mem_wb_stage.
//   - The stimulus process pushes each expected OUT value into out_q when it
//     issues an OUT instruction.
//   - The monitor process pops out_q on every out_valid pulse and compares.
//   - Register-file reads and the forwarding tap are checked against
//     hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [15:0] data_in;
    logic [2:0]  rd_in;
    logic        reg_write_in;
    logic        out_in;
    logic        valid_in;
    logic [2:0]  rs_addr;
    logic [2:0]  rt_addr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        fwd_valid;
    logic [2:0]  fwd_rd;
    logic [15:0] fwd_data;
    logic [15:0] out_port;
    logic        out_valid;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] out_q[$];

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .data_in      (data_in),
        .rd_in        (rd_in),
        .reg_write_in (reg_write_in),
        .out_in       (out_in),
        .valid_in     (valid_in),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .out_port     (out_port),
        .out_valid    (out_valid)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the next queued OUT value.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            n_checks++;
            if (out_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_pulse: got unexpected pulse with out_port=0x%04h, expected no pulse", out_port);
            end else begin
                logic [15:0] exp_v;
                exp_v = out_q.pop_front();
                if (out_port !== exp_v) begin
                    n_fail++;
                    $display("FAIL out_port: got 0x%04h, expected 0x%04h", out_port, exp_v);
                end else begin
                    $display("OUT txn: out_port=0x%04h", out_port);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] rd, input logic [15:0] d,
                         input logic rw, input logic o);
        valid_in     = v;
        rd_in        = rd;
        data_in      = d;
        reg_write_in = rw;
        out_in       = o;
        $display("drive: valid=%0b rd=%0d data=0x%04h rw=%0b out=%0b stall=%0b flush=%0b",
                 v, rd, d, rw, o, stall, flush);
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    endtask

    // Inputs change right after a falling edge. Checks run 1 time unit later,
    // which is still well before the next rising edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        stall   = 1'b0;
        flush   = 1'b0;
        rs_addr = 3'd0;
        rt_addr = 3'd0;
        idle();

        // 1. While reset is held, every register, the OUT port and its strobe are zero.
        repeat (2) next_cycle();
        for (int i = 0; i < 8; i++) begin
            rs_addr = 3'(i);
            rt_addr = 3'(7 - i);
            #1;
            check($sformatf("reset_rs[%0d]", i), rs_data, 16'h0000);
            check($sformatf("reset_rt[%0d]", 7 - i), rt_data, 16'h0000);
        end
        check("reset_out_port", out_port, 16'h0000);
        check("reset_out_valid", {15'b0, out_valid}, 16'h0000);
        check("reset_fwd_valid", {15'b0, fwd_valid}, 16'h0000);
        next_cycle();
        reset = 1'b0;

        // 2. Write r3 = 0x1234. The first read goes through the bypass; the next comes from the regfile.
        next_cycle();
        drive(1'b1, 3'd3, 16'h1234, 1'b1, 1'b0);
        next_cycle();
        idle();
        rs_addr = 3'd3;
        #1;
        check("byp_rs3", rs_data, 16'h1234);
        check("byp_fwd_valid", {15'b0, fwd_valid}, 16'h0001);
        check("byp_fwd_rd", {13'b0, fwd_rd}, 16'h0003);
        check("byp_fwd_data", fwd_data, 16'h1234);
        next_cycle();
        #1;
        check("rf_rs3", rs_data, 16'h1234);
        check("rf_fwd_valid", {15'b0, fwd_valid}, 16'h0000);

        // 3. An OUT of 0xBEEF followed by a 3-cycle stall gives exactly one pulse.
        drive(1'b1, 3'd6, 16'hBEEF, 1'b0, 1'b1);
        out_q.push_back(16'hBEEF);
        next_cycle();
        stall = 1'b1;
        idle();
        repeat (3) next_cycle();
        stall = 1'b0;
        #1;
        check("out_hold", out_port, 16'hBEEF);
        check("out_valid_low", {15'b0, out_valid}, 16'h0000);
        rs_addr = 3'd6;
        #1;
        check("out_no_write_r6", rs_data, 16'h0000);

        // 4. Flush and stall together with an incoming r5 write: the slot becomes a bubble.
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, 3'd5, 16'h00AA, 1'b1, 1'b0);
        next_cycle();
        flush = 1'b0;
        stall = 1'b0;
        idle();
        rs_addr = 3'd5;
        #1;
        check("flush_fwd_valid", {15'b0, fwd_valid}, 16'h0000);
        check("flush_rs5", rs_data, 16'h0000);
        next_cycle();
        #1;
        check("flush_rs5_later", rs_data, 16'h0000);

        // 5. Back-to-back writes to r2. Reading rt=2 every cycle must never give a stale value.
        rt_addr = 3'd2;
        drive(1'b1, 3'd2, 16'h0001, 1'b1, 1'b0);
        #1;
        check("b2b_rt2_before", rt_data, 16'h0000);
        next_cycle();
        drive(1'b1, 3'd2, 16'h0002, 1'b1, 1'b0);
        #1;
        check("b2b_rt2_first", rt_data, 16'h0001);
        next_cycle();
        idle();
        #1;
        check("b2b_rt2_second", rt_data, 16'h0002);
        next_cycle();
        #1;
        check("b2b_rt2_final", rt_data, 16'h0002);

        // 6. reg_write and out set together: both happen at the same edge.
        drive(1'b1, 3'd1, 16'h5A5A, 1'b1, 1'b1);
        out_q.push_back(16'h5A5A);
        next_cycle();
        idle();
        rs_addr = 3'd1;
        next_cycle();
        #1;
        check("both_rs1", rs_data, 16'h5A5A);
        check("both_out_port", out_port, 16'h5A5A);

        // 7. An asynchronous reset in mid-cycle drops the pending r7 write.
        drive(1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0);
        next_cycle();
        idle();
        rt_addr = 3'd7;
        #1;
        check("async_pre_fwd", {15'b0, fwd_valid}, 16'h0001);
        check("async_pre_rt7", rt_data, 16'hFFFF);
        #1;
        reset = 1'b1;
        #1;
        check("async_fwd_valid", {15'b0, fwd_valid}, 16'h0000);
        check("async_rt7", rt_data, 16'h0000);
        check("async_out_port", out_port, 16'h0000);
        rs_addr = 3'd3;
        #1;
        check("async_rs3_cleared", rs_data, 16'h0000);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        #1;
        check("async_rt7_after", rt_data, 16'h0000);

        repeat (2) next_cycle();
        check("out_q_drained", 16'(out_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_wb_stage

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus write-back logic, directly downstream of the memory stage.
- Captures the memory stage's selected write-back value, destination register and write-back controls, then commits one instruction per slot:
  - into an 8x16 register file, and/or
  - onto the OUT port.
- Provides two combinational register-file read ports (write-first bypass) for decode, and a forwarding tap for the hazard/forwarding unit.

Parameters:
- DATA_WIDTH, 16, width of register data, data_in and out_port
- REG_ADDR_WIDTH, 3, register index width; register file depth = 2**REG_ADDR_WIDTH (8)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold: do not capture a new slot this edge
- flush  input  1  load a bubble into the slot this edge (priority over stall)
- data_in  input  DATA_WIDTH  write-back value from memory stage (data_to_write)
- rd_in  input  REG_ADDR_WIDTH  destination register of incoming instruction
- reg_write_in  input  1  incoming instruction writes rd_in
- out_in  input  1  incoming instruction is OUT (drives out_port)
- valid_in  input  1  incoming slot holds a real instruction
- rs_addr  input  REG_ADDR_WIDTH  read port A address
- rt_addr  input  REG_ADDR_WIDTH  read port B address
- rs_data  output  DATA_WIDTH  read port A data
- rt_data  output  DATA_WIDTH  read port B data
- fwd_valid  output  1  slot will write a register at next edge
- fwd_rd  output  REG_ADDR_WIDTH  slot destination
- fwd_data  output  DATA_WIDTH  slot data
- out_port  output  DATA_WIDTH  registered output port
- out_valid  output  1  one-cycle pulse when out_port updates

Behaviour:
- Reset (async, immediate):
  - slot valid=0, slot data/rd/controls=0
  - all 8 registers=0
  - out_port=0, out_valid=0
- Slot = {valid, data, rd, reg_write, out}. The instruction in the slot commits at the rising edge ending its WB cycle:
  - if valid & reg_write: regfile[rd] <= data
  - if valid & out: out_port <= data and out_valid=1 for the following cycle; otherwise out_valid=0
  - out_port holds its value until the next OUT commit.
- Slot update at each edge, evaluated after commit; priority reset > flush > stall > capture:
  - flush=1: slot becomes a bubble (valid=0). Inputs are discarded. The current slot still commits.
  - stall=1, flush=0: the current slot commits, then its valid is cleared. Each instruction commits exactly once; no double OUT pulse. Inputs are not captured; upstream must hold them.
  - otherwise: slot <= {valid_in, data_in, rd_in, reg_write_in, out_in}.
- Latency:
  - data_in captured at edge N; register file updated and out_port driven at edge N+1.
  - Value readable via rs/rt in cycle N..N+1 through the bypass.
- Read ports are combinational, with write-first bypass:
  - if slot valid & reg_write & rd==rs_addr, rs_data = slot data; else regfile[rs_addr]. Same for rt.
- No hard-wired zero register; all 8 registers are writable.
- fwd_valid = slot valid & reg_write; fwd_rd and fwd_data mirror the slot. These are combinational from the slot registers.
- A bubble (valid=0) never writes or pulses, regardless of the reg_write/out bits.
- reg_write and out may both be set; both actions happen at the same edge.
- Reset asserted mid-slot: the pending commit is lost and no write occurs.

Decomposition:
- Shared package holds DATA_WIDTH, REG_ADDR_WIDTH defaults and a wb_slot struct/typedef {valid, data, rd, reg_write, out}, so memory_stage and the hazard unit can reuse them.
- One natural sub-module: register_file (8x16, one sync write port, two async read ports, async reset to 0). The bypass mux stays in mem_wb_stage.

Test Plan:
1. Reset, then read all 8 registers -> rs_data/rt_data=0x0000, out_port=0, out_valid=0.
2. Capture {valid=1, data=0x1234, rd=3, reg_write=1}; in the next cycle rs_addr=3 -> rs_data=0x1234 via bypass and fwd_valid=1; after the following edge, regfile[3]=0x1234 with no bypass.
3. Capture {valid=1, data=0xBEEF, out=1}, then hold stall=1 for 3 cycles -> out_port=0xBEEF, out_valid high exactly one cycle, no register written.
4. flush=1 and stall=1 on the same edge as an incoming {rd=5, data=0x00AA, reg_write=1} -> slot becomes a bubble, regfile[5] unchanged, fwd_valid=0.
5. Back-to-back writes to rd=2 (0x0001 then 0x0002), reading rt_addr=2 each cycle -> sees 0x0001 then 0x0002 with no stale cycle; final regfile[2]=0x0002.
6. Assert reset asynchronously mid-cycle while the slot holds {rd=7, data=0xFFFF, reg_write=1} -> outputs clear immediately and regfile[7]=0 after release.
